// File: rtl/chip_test_sequencer.sv
// Start-button front end: pulses Run, waits for Done or a timeout, holds the verdict until the next press.
// Pass/fail tallies are built only when CHIP_TALLY_EN is defined; otherwise PassCount/FailCount read 0.
module chip_test_sequencer #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic             Run,
  input  logic             Done,
  input  logic             RSLT,
  output logic             DISP_RSLT,
  output logic             Busy,
  output logic             Pass,
  output logic             Fail,
  output logic             Timeout,
  output logic [CNT_W-1:0] PassCount,
  output logic [CNT_W-1:0] FailCount
);
  localparam int            TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DISPLAY,
    S_CLEAR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_delay;
  logic          w_start_edge;
  logic [TW-1:0] r_cnt;
  logic          w_latch;
  logic          w_good;
  logic          w_timeout;
  logic          r_pass;
  logic          r_fail;
  logic          r_timeout;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_delay <= 1'b0;
    end else begin
      r_sync1 <= Start;
      r_sync2 <= r_sync1;
      r_delay <= r_sync2;
    end
  end

  assign w_start_edge = r_sync2 & ~r_delay;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Done takes priority over the terminal count when both land in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_good    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start_edge) w_next = S_RUN;
      S_RUN:     w_next = S_WAIT;
      S_WAIT: begin
        if (Done) begin
          w_latch = 1'b1;
          w_good  = RSLT;
          w_next  = S_DISPLAY;
        end else if (r_cnt == TERM) begin
          w_latch   = 1'b1;
          w_timeout = 1'b1;
          w_next    = S_DISPLAY;
        end
      end
      S_DISPLAY: if (w_start_edge) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_latch) begin
      r_pass    <= w_good;
      r_fail    <= ~w_good;
      r_timeout <= w_timeout;
    end else if (w_next == S_CLEAR) begin
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end
  end

  assign Run       = (r_state == S_RUN);
  assign Busy      = (r_state == S_RUN) || (r_state == S_WAIT);
  assign DISP_RSLT = (r_state == S_DISPLAY);
  assign Pass      = r_pass;
  assign Fail      = r_fail;
  assign Timeout   = r_timeout;

`ifdef CHIP_TALLY_EN
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  // Saturating tallies; only Reset clears them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (w_latch) begin
      if (w_good && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (!w_good && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  assign PassCount = r_pass_cnt;
  assign FailCount = r_fail_cnt;
`else
  assign PassCount = '0;
  assign FailCount = '0;
`endif

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: directed scenarios plus random Start/Done traffic against an in-bench reference model.
module tb_chip_test_sequencer;
  localparam int T    = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CHIP_TALLY_EN
  localparam bit TALLY = 1'b1;
`else
  localparam bit TALLY = 1'b0;
`endif

  logic          Clk   = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Run;
  logic          Done;
  logic          RSLT;
  logic          DISP_RSLT;
  logic          Busy;
  logic          Pass;
  logic          Fail;
  logic          Timeout;
  logic [CW-1:0] PassCount;
  logic [CW-1:0] FailCount;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int run_cnt = 0;

  // Tester stand-in: answers tst_delay cycles after it sees Run, unless told to hang.
  int tst_delay = 10;
  bit tst_rslt  = 1'b1;
  bit tst_hang  = 1'b0;
  bit n_done    = 1'b0;
  bit n_rslt    = 1'b0;
  bit t_act     = 1'b0;
  bit t_done    = 1'b0;
  bit t_r       = 1'b0;
  bit t_h       = 1'b0;
  int t_cnt     = 0;
  int t_tgt     = 0;

  assign Done = t_done | n_done;
  assign RSLT = t_done ? t_r : n_rslt;

  chip_test_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Run(Run), .Done(Done), .RSLT(RSLT),
    .DISP_RSLT(DISP_RSLT), .Busy(Busy), .Pass(Pass), .Fail(Fail), .Timeout(Timeout),
    .PassCount(PassCount), .FailCount(FailCount)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the test phase, cycles spent waiting, latched verdict and tallies.
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_DISP = 3, M_CLEAR = 4;
  int m_mode = M_IDLE;
  int m_waited = 0;
  int m_pc = 0;
  int m_fc = 0;
  bit m_pass = 0, m_fail = 0, m_to = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  task automatic model_reset();
    m_mode = M_IDLE; m_waited = 0; m_pc = 0; m_fc = 0;
    m_pass = 0; m_fail = 0; m_to = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_verdict(input bit good, input bit to);
    m_pass = good; m_fail = !good; m_to = to; m_mode = M_DISP;
    if (TALLY && good && m_pc < CMAX) m_pc++;
    if (TALLY && !good && m_fc < CMAX) m_fc++;
  endtask

  task automatic model_step();
    // A press acts once Start has been seen high two edges ago after being low three edges ago.
    bit press;
    press = h2 & ~h3;
    case (m_mode)
      M_IDLE: if (press) m_mode = M_RUN;
      M_RUN: begin m_mode = M_WAIT; m_waited = 0; end
      M_WAIT: begin
        m_waited++;
        if (Done === 1'b1) model_verdict(RSLT === 1'b1, 1'b0);
        else if (m_waited == T) model_verdict(1'b0, 1'b1);
      end
      M_DISP: if (press) begin m_mode = M_CLEAR; m_pass = 0; m_fail = 0; m_to = 0; end
      default: m_mode = M_RUN;
    endcase
    h3 = h2; h2 = h1; h1 = Start;
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else model_step();
  end

  task automatic compare_all();
    chk("run", Run, m_mode == M_RUN);
    chk("busy", Busy, (m_mode == M_RUN) || (m_mode == M_WAIT));
    chk("disp", DISP_RSLT, m_mode == M_DISP);
    chk("pass", Pass, m_pass);
    chk("fail", Fail, m_fail);
    chk("timeout", Timeout, m_to);
    chk("passcount", PassCount, m_pc);
    chk("failcount", FailCount, m_fc);
  endtask

  always @(negedge Clk) compare_all();

  task automatic tester_step();
    if (Run === 1'b1) run_cnt++;
    if (Reset) begin
      t_act = 0; t_done = 0;
    end else begin
      t_done = 0;
      if (Run === 1'b1) begin
        t_act = 1; t_cnt = 0; t_tgt = tst_delay; t_r = tst_rslt; t_h = tst_hang;
      end else if (t_act) begin
        t_cnt++;
        if (t_cnt == t_tgt && !t_h) begin t_done = 1; t_act = 0; end
        if (DISP_RSLT === 1'b1) t_act = 0;
      end
    end
  endtask

  always @(negedge Clk) tester_step();

  task automatic press(input int n);
    Start = 1'b1;
    repeat (n) @(negedge Clk);
    Start = 1'b0;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return Run;
      1:       return DISP_RSLT;
      2:       return Pass;
      3:       return Timeout;
      default: return Busy;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (sig(s) === 1'b1) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_sig%0d: not seen within %0d cycles", s, budget);
    end
  endtask

  task automatic async_reset();
    #2 Reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int at, at2, r0, p, hold;
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_run", Run, 0);       chk("rst_disp", DISP_RSLT, 0);
    chk("rst_busy", Busy, 0);     chk("rst_pass", Pass, 0);
    chk("rst_fail", Fail, 0);     chk("rst_to", Timeout, 0);
    chk("rst_pc", PassCount, 0);  chk("rst_fc", FailCount, 0);

    // Done in IDLE is ignored.
    n_done = 1; n_rslt = 1;
    repeat (4) @(negedge Clk);
    n_done = 0; n_rslt = 0;
    chk("idle_done_busy", Busy, 0); chk("idle_done_disp", DISP_RSLT, 0); chk("idle_done_pass", Pass, 0);

    // Good chip, button held 10 cycles.
    tst_delay = 10; tst_rslt = 1; tst_hang = 0; r0 = run_cnt; p = cyc + 1;
    fork press(10); join_none
    wait_sig(0, 10, at);
    chk("good_run_lat", at, p + 2);
    wait_sig(2, 40, at2);
    chk("good_pass_lat", at2, at + 11);
    chk("good_disp", DISP_RSLT, 1); chk("good_busy", Busy, 0); chk("good_fail", Fail, 0);
    chk("good_runs", run_cnt - r0, 1); chk("good_pc", PassCount, TALLY ? 1 : 0);

    // Retest giving a bad verdict.
    tst_rslt = 0;
    fork press(3); join_none
    wait_sig(0, 10, at);
    wait_sig(1, 40, at2);
    chk("bad_fail", Fail, 1); chk("bad_pass", Pass, 0);

    // Retest from a bad verdict: one CLEAR cycle, then Run; the tester then hangs.
    tst_hang = 1; p = cyc + 1;
    fork press(3); join_none
    repeat (3) @(negedge Clk);
    chk("clr_disp", DISP_RSLT, 0); chk("clr_pass", Pass, 0); chk("clr_fail", Fail, 0);
    chk("clr_to", Timeout, 0); chk("clr_run", Run, 0);
    @(negedge Clk);
    chk("clr_then_run", Run, 1);
    at = cyc;
    wait_sig(3, 40, at2);
    chk("hang_lat", at2, at + 1 + T);
    chk("hang_fail", Fail, 1); chk("hang_pass", Pass, 0); chk("hang_disp", DISP_RSLT, 1);
    chk("hang_fc", FailCount, TALLY ? 2 : 0);

    // Done on the terminal-count cycle, with extra presses during WAIT.
    tst_hang = 0; tst_delay = T; tst_rslt = 1; r0 = run_cnt;
    fork press(2); join_none
    wait_sig(0, 10, at);
    fork begin press(2); repeat (2) @(negedge Clk); press(2); end join_none
    wait_sig(2, 40, at2);
    chk("tie_lat", at2, at + 1 + T);
    chk("tie_to", Timeout, 0); chk("tie_fail", Fail, 0); chk("extra_runs", run_cnt - r0, 1);

    // Asynchronous reset in WAIT, RUN and DISPLAY.
    tst_hang = 1;
    fork press(2); join_none
    wait_sig(0, 10, at);
    @(negedge Clk);
    chk("pre_rst_busy", Busy, 1);
    async_reset();
    chk("rstw_busy", Busy, 0); chk("rstw_run", Run, 0); chk("rstw_disp", DISP_RSLT, 0);
    chk("rstw_pc", PassCount, 0); chk("rstw_fc", FailCount, 0);
    release_reset();
    tst_hang = 0; tst_delay = 3;
    fork press(2); join_none
    wait_sig(0, 10, at);
    async_reset();
    chk("rstr_run", Run, 0); chk("rstr_busy", Busy, 0);
    release_reset();
    fork press(2); join_none
    wait_sig(1, 30, at);
    async_reset();
    chk("rstd_disp", DISP_RSLT, 0); chk("rstd_pass", Pass, 0); chk("rstd_fail", Fail, 0);
    release_reset();

    // Five passes in a row saturate a 2-bit tally at 3.
    for (int i = 0; i < 5; i++) begin
      tst_delay = 4; tst_rslt = 1; tst_hang = 0;
      fork press(2); join_none
      wait_sig(0, 10, at);
      wait_sig(1, 20, at2);
    end
    chk("sat_pc", PassCount, TALLY ? 3 : 0);
    chk("sat_fc", FailCount, 0);

    // Random traffic, checked every cycle by the model.
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      if (hold == 0) begin Start = ~Start; hold = $urandom_range(1, 14); end
      else hold--;
      n_done    = ($urandom_range(0, 15) == 0);
      n_rslt    = 1'($urandom);
      tst_delay = $urandom_range(1, 20);
      tst_rslt  = 1'($urandom);
      tst_hang  = ($urandom_range(0, 7) == 0);
    end
    Start = 0; n_done = 0;
    repeat (40) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
